// File: rtl/stopwatch_ctrl.sv
`default_nettype none
//============================================================================
// Module      : stopwatch_ctrl
// Description : Control FSM for a 3-digit BCD stopwatch counter. Turns the
//               debounced start/stop and lap/clear button levels into the
//               counter's go/clr controls, supports a lap freeze of the
//               displayed digits, optional auto-stop at 9.9.9 and a clean
//               clear out of reset.
// Revision    : 1.0 - initial release
//============================================================================
module stopwatch_ctrl #(
    parameter logic AUTO_STOP = 1'b1   // 1: stop at 9,9,9; 0: let the counter wrap
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_ss,
    input  logic       btn_lap,
    input  logic [3:0] d2,
    input  logic [3:0] d1,
    input  logic [3:0] d0,
    output logic       go,
    output logic       clr,
    output logic [3:0] disp2,
    output logic [3:0] disp1,
    output logic [3:0] disp0,
    output logic       running,
    output logic       lap_active
);

    // State encoding
    localparam logic [2:0] c_ST_CLR   = 3'd0;
    localparam logic [2:0] c_ST_IDLE  = 3'd1;
    localparam logic [2:0] c_ST_RUN   = 3'd2;
    localparam logic [2:0] c_ST_PAUSE = 3'd3;
    localparam logic [2:0] c_ST_LAP   = 3'd4;

    localparam logic [3:0] c_BCD_NINE = 4'd9;

    logic [2:0] r_state;
    logic [2:0] w_state_nxt;
    logic       r_prev_ss;
    logic       r_prev_lap;
    logic       w_ss_ev;
    logic       w_lap_ev;
    logic       w_at_max;
    logic       w_capture;
    logic       w_go_nxt;
    logic       w_clr_nxt;
    logic       r_go;
    logic       r_clr;
    logic [3:0] r_lap2;
    logic [3:0] r_lap1;
    logic [3:0] r_lap0;

    // Rising-edge events; start/stop takes priority when both rise together
    always_comb begin
        w_ss_ev  = btn_ss & ~r_prev_ss;
        w_lap_ev = btn_lap & ~r_prev_lap & ~w_ss_ev;
        w_at_max = AUTO_STOP && (d2 == c_BCD_NINE) && (d1 == c_BCD_NINE)
                             && (d0 == c_BCD_NINE);
    end

    // Previous button levels; set on reset so a held button needs a re-press
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev_ss  <= 1'b1;
            r_prev_lap <= 1'b1;
        end else begin
            r_prev_ss  <= btn_ss;
            r_prev_lap <= btn_lap;
        end
    end

    // Next-state logic and next values of the registered counter controls
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        case (r_state)
            c_ST_CLR: begin
                w_state_nxt = c_ST_IDLE;
            end
            c_ST_IDLE: begin
                if (w_ss_ev) begin
                    w_state_nxt = c_ST_RUN;
                end
            end
            c_ST_RUN: begin
                if (w_ss_ev) begin
                    w_state_nxt = c_ST_PAUSE;
                end else if (w_at_max) begin
                    w_state_nxt = c_ST_PAUSE;
                end else if (w_lap_ev) begin
                    w_state_nxt = c_ST_LAP;
                    w_capture   = 1'b1;
                end
            end
            c_ST_PAUSE: begin
                if (w_ss_ev) begin
                    w_state_nxt = c_ST_RUN;
                end else if (w_lap_ev) begin
                    w_state_nxt = c_ST_CLR;
                end
            end
            c_ST_LAP: begin
                if (w_ss_ev) begin
                    w_state_nxt = c_ST_PAUSE;
                end else if (w_at_max) begin
                    // Auto-stop drops the lap freeze along with the run
                    w_state_nxt = c_ST_PAUSE;
                end else if (w_lap_ev) begin
                    w_state_nxt = c_ST_RUN;
                end
            end
            default: begin
                w_state_nxt = c_ST_CLR;
            end
        endcase
        w_go_nxt  = (w_state_nxt == c_ST_RUN) || (w_state_nxt == c_ST_LAP);
        w_clr_nxt = (w_state_nxt == c_ST_CLR);
    end

    // State register with go/clr held in flops that track the state decode
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_CLR;
            r_go    <= 1'b0;
            r_clr   <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_go    <= w_go_nxt;
            r_clr   <= w_clr_nxt;
        end
    end

    // Lap snapshot, written only when entering LAP from RUN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lap2 <= 4'd0;
            r_lap1 <= 4'd0;
            r_lap0 <= 4'd0;
        end else if (w_capture) begin
            r_lap2 <= d2;
            r_lap1 <= d1;
            r_lap0 <= d0;
        end
    end

    // Status decodes and display mux between live digits and the snapshot
    always_comb begin
        go         = r_go;
        clr        = r_clr;
        running    = (r_state == c_ST_RUN) || (r_state == c_ST_LAP);
        lap_active = (r_state == c_ST_LAP);
        disp2      = lap_active ? r_lap2 : d2;
        disp1      = lap_active ? r_lap1 : d1;
        disp0      = lap_active ? r_lap0 : d0;
    end

endmodule
`default_nettype wire

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Control FSM for the 3-digit stopwatch BCD counter. Converts two debounced push-button levels into the counter's `go`/`clr` controls and adds lap-freeze, auto-stop at 9.9.9 and a clean power-up clear. Sits between the debouncers and the counter. Drives the 7-segment display path with either the live counter digits or a frozen lap snapshot.

## Interface
Parameters:
- `AUTO_STOP`, 1: 1 = stop counting when the digits reach 9,9,9; 0 = let the counter wrap to 0,0,0.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `btn_ss`  in  1  start/stop button, debounced level.
- `btn_lap`  in  1  lap/clear button, debounced level.
- `d2, d1, d0`  in  4 each  live BCD digits from the counter.
- `go`  out  1  counter enable; registered.
- `clr`  out  1  counter synchronous clear; registered.
- `disp2, disp1, disp0`  out  4 each  digits for display.
- `running`  out  1  high in RUN or LAP.
- `lap_active`  out  1  high in LAP.

## Operation
- Edge detect:
  - `prev_ss` and `prev_lap` registers; `ss_ev = btn_ss & ~prev_ss`, `lap_ev = btn_lap & ~prev_lap`.
  - Both prev registers reset to 1, so a button held through reset produces no event until it is released and pressed again.
- Simultaneous `ss_ev` and `lap_ev`: `ss_ev` wins and `lap_ev` is discarded.
- States, with outputs as Moore decodes of registered state (`go`, `clr` are flops):
  - CLR: `go`=0, `clr`=1, live display. Always moves to IDLE next cycle.
  - IDLE: `go`=0, `clr`=0. `ss_ev` → RUN. `lap_ev` is ignored.
  - RUN: `go`=1. `ss_ev` → PAUSE. `lap_ev` → LAP and captures `d2..d0` into `lap2..lap0`.
  - PAUSE: `go`=0. `ss_ev` → RUN. `lap_ev` → CLR.
  - LAP: `go`=1, counter keeps running, display frozen. `lap_ev` → RUN and releases the freeze. `ss_ev` → PAUSE, display returns to live.
- Auto-stop (`AUTO_STOP`=1):
  - In RUN or LAP, when `{d2,d1,d0}` = 9,9,9 and there is no `ss_ev`, go to PAUSE.
  - The lap snapshot is discarded on this transition.
- Display: `disp* = lap_active ? lap* : d*`. This mux is combinational.
- `lap2..lap0` reset to 0 and are written only on RUN→LAP.
- BCD inputs are assumed to be legal values 0-9. No arithmetic is performed on them; only the 9,9,9 compare.

## Timing
- Reset:
  - While `reset`=1, state is forced to CLR, so `go`=0, `clr`=1, `running`=0, `lap_active`=0, `lap*`=0.
  - The first cycle after release is still CLR (`clr`=1). IDLE follows one cycle later.
  - Reset mid-RUN clears the counter the same way; no lap value survives.
- Event latency: a button level first sampled high at edge k (prev low) changes state and `go`/`clr` at edge k. The new values are visible in the cycle after edge k.
- Lap capture: at edge k, `lap*` takes the `d*` values present just before edge k.
- Auto-stop latency: digits become 9,9,9 after edge t; `go` falls at edge t+1.
  - This is safe because the counter's tick period is ≫2 cycles, so it never advances past 9,9,9.
- `clr` is high for exactly 1 cycle per PAUSE→CLR transition.
  - The counter clears on the edge after `clr` rises.
  - `disp*` show 0,0,0 once in IDLE.
- A button held high generates exactly one event, and no event on release.

## Test plan
- Reset held 3 cycles with `btn_ss`=1 → `clr`=1 and `go`=0 during reset plus 1 cycle, then IDLE. No RUN until `btn_ss` goes 0→1.
- IDLE, pulse `btn_ss` → `go`=1 the cycle after the sampling edge. Pulse again → `go`=0 (PAUSE), digits hold.
- RUN with digits 1,2,3, pulse `btn_lap` → `disp`=1,2,3 frozen while `d*` advance to 1,2,7. Pulse `btn_lap` → `disp` follows `d*`.
- PAUSE at 4,5,6, pulse `btn_lap` → `clr`=1 for one cycle, then IDLE with `disp`=0,0,0. Pulse `btn_lap` in IDLE → no change.
- Both buttons rise on the same edge in RUN → PAUSE, `lap_active`=0, `lap*` unchanged.
- `AUTO_STOP`=1, drive `d*`=9,9,9 in LAP → state PAUSE, `go`=0 one edge later, `disp` live 9,9,9. Repeat with `AUTO_STOP`=0 → `go` stays 1.
